maxpool1d_seq: RTL and testbench
================================

MAXPOOL1D_SEQ -- requirements
Module: maxpool1d_seq

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 40: positions per channel in the input frame.
REQ-002 SHALL have parameter NUM_FILTERS, default 8: channels, matching the upstream conv stage filter count.
REQ-003 SHALL have parameter POOL_SIZE, default 2: pooling window, equal to the stride.
REQ-004 SHALL have parameter ACTIV_BITS, default 16: element width.
REQ-005 SHALL define the derived localparam OUT_WIDTH = INPUT_WIDTH / POOL_SIZE (floor).
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port data_in, input, INPUT_WIDTH*NUM_FILTERS*ACTIV_BITS: conv output frame; element (n,f) at bit offset (n*NUM_FILTERS+f)*ACTIV_BITS.
REQ-009 SHALL have port data_valid, input, 1: single-cycle frame-valid strobe.
REQ-010 SHALL have port data_out, output reg, OUT_WIDTH*NUM_FILTERS*ACTIV_BITS: pooled frame; element (o,f) at offset (o*NUM_FILTERS+f)*ACTIV_BITS.
REQ-011 SHALL have port data_out_valid, output reg, 1: one-cycle pulse when data_out is updated.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, COMPUTE and DONE.
REQ-014 IDLE: when data_valid=1, SHALL latch data_in into an internal frame buffer, clear index o to 0, and go to COMPUTE.
REQ-015 COMPUTE: each cycle, for every f, SHALL write result(o,f) = max of elements (o*POOL_SIZE+k, f) for k=0..POOL_SIZE-1 into an internal result register.
REQ-016 SHALL use an unsigned comparison; equal values give the same value.
REQ-017 SHALL increment o each COMPUTE cycle; after o=OUT_WIDTH-1 it SHALL go to DONE.
REQ-018 DONE: SHALL copy the result register to data_out, pulse data_out_valid for exactly one cycle, and return to IDLE.
REQ-019 Latency: data_valid sampled at edge T gives data_out_valid high during the cycle after edge T+OUT_WIDTH+1; the default parameters give 21 cycles.
REQ-020 data_out SHALL change only on the edge that raises data_out_valid and SHALL otherwise hold its last value.
REQ-021 Input positions at index >= OUT_WIDTH*POOL_SIZE (remainder when not divisible) SHALL be ignored.
REQ-022 data_valid while busy=1 SHALL be dropped: no effect on the buffer, index, or state.
REQ-023 data_valid in the same cycle as DONE SHALL be dropped; the next accepted frame needs data_valid in IDLE.
REQ-024 Back-to-back accepted frames SHALL be spaced at least OUT_WIDTH+2 cycles apart.

Reset
REQ-025 On rst_n=0, at any time including mid-COMPUTE, the block SHALL immediately go to state IDLE with o=0, data_out=0, data_out_valid=0, and the buffer and result register cleared to 0.
REQ-026 After rst_n deasserts, the block SHALL accept data_valid on the first rising edge.

Configuration
REQ-027 When macro MAXPOOL_DROP_CNT_EN is defined, SHALL add output drop_count [7:0].
REQ-028 drop_count SHALL be a saturating count (max 255) of data_valid pulses dropped under REQ-022/023, and SHALL reset to 0.
REQ-029 When MAXPOOL_DROP_CNT_EN is undefined, the drop_count port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Default parameters; element (n,f)=n*8+f; one data_valid pulse -> data_out_valid exactly 21 cycles later; element (o,f) = (2o+1)*8+f (e.g. (0,0)=8, (19,7)=319).
REQ-031 Pairs (16'hFFFF,16'h0001) and (16'h0000,16'h0000) -> 16'hFFFF and 16'h0000 (unsigned, tie).
REQ-032 INPUT_WIDTH=5, POOL_SIZE=2; position 4 set to 16'h7FFF, others 1 -> OUT_WIDTH=2 and every output is 1.
REQ-033 Second data_valid 5 cycles after the first -> a single data_out_valid pulse carrying frame 1; with MAXPOOL_DROP_CNT_EN, drop_count=1.
REQ-034 rst_n low at cycle 10 of COMPUTE -> data_out=0, busy=0, no data_out_valid pulse; a new frame after release completes in 21 cycles.
REQ-035 300 dropped pulses with MAXPOOL_DROP_CNT_EN -> drop_count saturates at 255.

Source files
------------

// File: rtl/maxpool1d_seq.sv
// maxpool1d_seq -- sequential 1-D max pooling over a multi-channel frame.
//
// A whole conv frame is captured on a single-cycle data_valid strobe. One
// output position per cycle is then reduced (all channels in parallel) into a
// result register. Once every position is done, the result is copied to
// data_out together with a one-cycle data_out_valid pulse.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   data_in        : frame, element (n,f) at (n*NUM_FILTERS+f)*ACTIV_BITS
//   data_valid     : single-cycle frame strobe, honoured only when idle
//   data_out       : pooled frame, element (o,f) at (o*NUM_FILTERS+f)*ACTIV_BITS
//   data_out_valid : one-cycle pulse on the cycle data_out updates
//   busy           : high whenever a frame is in flight
//   drop_count     : (MAXPOOL_DROP_CNT_EN only) saturating count of strobes
//                    ignored because the block was busy
//
// Build option: define MAXPOOL_DROP_CNT_EN to add the drop_count output.

// Per-channel window reducer: unsigned max over POOL_SIZE elements.
module maxpool_lane #(
  parameter int POOL_SIZE  = 2,
  parameter int ACTIV_BITS = 16
) (
  input  logic [POOL_SIZE*ACTIV_BITS-1:0] win_i,
  output logic [ACTIV_BITS-1:0]           max_o
);
  logic [ACTIV_BITS-1:0] m;
  always_comb begin
    m = win_i[ACTIV_BITS-1:0];
    for (int k = 1; k < POOL_SIZE; k++)
      if (win_i[k*ACTIV_BITS +: ACTIV_BITS] > m)
        m = win_i[k*ACTIV_BITS +: ACTIV_BITS];
    max_o = m;
  end
endmodule

module maxpool1d_seq #(
  parameter int INPUT_WIDTH = 40,
  parameter int NUM_FILTERS = 8,
  parameter int POOL_SIZE   = 2,
  parameter int ACTIV_BITS  = 16
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [INPUT_WIDTH*NUM_FILTERS*ACTIV_BITS-1:0]     data_in,
  input  logic                                              data_valid,
  output logic [(INPUT_WIDTH/POOL_SIZE)*NUM_FILTERS*ACTIV_BITS-1:0] data_out,
  output logic                                              data_out_valid,
  output logic                                              busy
`ifdef MAXPOOL_DROP_CNT_EN
  ,
  output logic [7:0]                                        drop_count
`endif
);
  localparam int OUT_WIDTH = INPUT_WIDTH / POOL_SIZE;
  // Trailing positions that do not fill a whole window are never stored.
  localparam int USED_BITS = OUT_WIDTH * POOL_SIZE * NUM_FILTERS * ACTIV_BITS;
  localparam int OUT_BITS  = OUT_WIDTH * NUM_FILTERS * ACTIV_BITS;
  localparam int OW        = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [OW-1:0] O_LAST = OW'(OUT_WIDTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [OW-1:0]        o_q, o_d;
  logic [USED_BITS-1:0] buf_q;
  logic [OUT_BITS-1:0]  res_q;
  logic [OUT_BITS-1:0]  dout_q;
  logic                 dov_q;
  logic                 accept;

  logic [NUM_FILTERS-1:0][ACTIV_BITS-1:0] lane_max;

  assign accept         = (state_q == S_IDLE) && data_valid;
  assign busy           = (state_q != S_IDLE);
  assign data_out       = dout_q;
  assign data_out_valid = dov_q;

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d = S_COMPUTE;
          o_d     = '0;
        end
      end
      S_COMPUTE: begin
        if (o_q == O_LAST) begin
          state_d = S_DONE;
          o_d     = '0;
        end else begin
          o_d = o_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gather the window for the current output position of each channel.
  // Channels are interleaved in the buffer, so a window is not contiguous.
  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane
    logic [POOL_SIZE*ACTIV_BITS-1:0] win;
    always_comb begin
      win = '0;
      for (int k = 0; k < POOL_SIZE; k++)
        win[k*ACTIV_BITS +: ACTIV_BITS] =
          buf_q[((int'(o_q)*POOL_SIZE + k)*NUM_FILTERS + f)*ACTIV_BITS +: ACTIV_BITS];
    end
    maxpool_lane #(
      .POOL_SIZE (POOL_SIZE),
      .ACTIV_BITS(ACTIV_BITS)
    ) u_lane (
      .win_i(win),
      .max_o(lane_max[f])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      buf_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      dov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      dov_q   <= (state_q == S_DONE);
      if (accept)
        buf_q <= data_in[USED_BITS-1:0];
      if (state_q == S_COMPUTE)
        for (int f = 0; f < NUM_FILTERS; f++)
          res_q[(int'(o_q)*NUM_FILTERS + f)*ACTIV_BITS +: ACTIV_BITS] <= lane_max[f];
      if (state_q == S_DONE)
        dout_q <= res_q;
    end
  end

`ifdef MAXPOOL_DROP_CNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_q <= '0;
    else if (data_valid && (state_q != S_IDLE) && (drop_q != 8'hFF))
      drop_q <= drop_q + 8'd1;
  end
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_maxpool1d_seq.sv
module tb_maxpool1d_seq;
  localparam int IW = 40, NF = 8, PS = 2, AB = 16;
  localparam int OW = IW / PS;
  localparam int IN_BITS  = IW * NF * AB;
  localparam int OUT_BITS = OW * NF * AB;
  localparam int LAT = OW + 1;

  // Small instance with a remainder position.
  localparam int IW5 = 5, NF5 = 2;
  localparam int OW5 = IW5 / PS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [IN_BITS-1:0]  data_in;
  logic                data_valid;
  logic [OUT_BITS-1:0] data_out;
  logic                data_out_valid;
  logic                busy;

  logic [IW5*NF5*AB-1:0] din5;
  logic                  dv5;
  logic [OW5*NF5*AB-1:0] dout5;
  logic                  dov5;
  logic                  busy5;

`ifdef MAXPOOL_DROP_CNT_EN
  logic [7:0] drop_count;
  logic [7:0] drop_count5;
`endif

  always #5 clk = ~clk;

  maxpool1d_seq #(.INPUT_WIDTH(IW), .NUM_FILTERS(NF), .POOL_SIZE(PS), .ACTIV_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy)
`ifdef MAXPOOL_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  maxpool1d_seq #(.INPUT_WIDTH(IW5), .NUM_FILTERS(NF5), .POOL_SIZE(PS), .ACTIV_BITS(AB)) dut5 (
    .clk(clk), .rst_n(rst_n), .data_in(din5), .data_valid(dv5),
    .data_out(dout5), .data_out_valid(dov5), .busy(busy5)
`ifdef MAXPOOL_DROP_CNT_EN
    , .drop_count(drop_count5)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AB-1:0] el(input logic [OUT_BITS-1:0] v, input int o, input int f);
    return v[(o*NF + f)*AB +: AB];
  endfunction

  task automatic chk_frame(input string nm, input logic [OUT_BITS-1:0] act, input logic [OUT_BITS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < OW*NF; i++)
        if (act[i*AB +: AB] !== exp[i*AB +: AB]) begin
          $display("FAIL %s: elem o=%0d f=%0d got %h expected %h (t=%0t)",
                   nm, i / NF, i % NF, act[i*AB +: AB], exp[i*AB +: AB], $time);
          break;
        end
    end
  endtask

  // Reference: each output is the unsigned max of its window; trailing
  // positions beyond OW*PS never enter any window.
  function automatic logic [OUT_BITS-1:0] pool_ref(input logic [IN_BITS-1:0] d);
    logic [OUT_BITS-1:0] r;
    logic [AB-1:0] m, v;
    r = '0;
    for (int o = 0; o < OW; o++)
      for (int f = 0; f < NF; f++) begin
        m = '0;
        for (int k = 0; k < PS; k++) begin
          v = d[((o*PS + k)*NF + f)*AB +: AB];
          if (v > m) m = v;
        end
        r[(o*NF + f)*AB +: AB] = m;
      end
    return r;
  endfunction

  // Transaction-level model: an accepted frame produces its result LAT
  // edges later; strobes before the block is free again are dropped.
  int ecnt = 0;
  int next_ok = 0;
  int due = 0;
  bit pend = 0;
  bit exp_v = 0;
  logic [OUT_BITS-1:0] pend_frame = '0;
  logic [OUT_BITS-1:0] exp_out = '0;
  int drops = 0;

  always @(posedge clk) begin
    ecnt++;
    if (!rst_n) begin
      pend = 0; exp_v = 0; exp_out = '0; next_ok = 0; drops = 0;
    end else begin
      exp_v = 0;
      if (pend && ecnt == due) begin
        exp_v = 1; exp_out = pend_frame; pend = 0;
      end
      if (data_valid) begin
        if (ecnt >= next_ok) begin
          pend = 1; due = ecnt + LAT; next_ok = ecnt + LAT + 1;
          pend_frame = pool_ref(data_in);
        end else if (drops < 255) begin
          drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("data_out_valid", 64'(data_out_valid), 64'(exp_v));
    chk("busy", 64'(busy), 64'(pend));
    chk_frame("data_out", data_out, exp_out);
`ifdef MAXPOOL_DROP_CNT_EN
    chk("drop_count", 64'(drop_count), 64'(drops));
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [IN_BITS-1:0] d, output int t);
    data_in = d; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    t = ecnt;
  endtask

  task automatic wait_valid(input string nm, input int t0);
    int lat;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (data_out_valid) begin
        lat = ecnt - t0;
        break;
      end
    end
    #1;
    chk(nm, 64'(lat), 64'(LAT));
  endtask

  logic [IN_BITS-1:0]  fr, fa;
  logic [OUT_BITS-1:0] rr;
  int t0;

  initial begin
    data_in = '0; data_valid = 1'b0; din5 = '0; dv5 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk_frame("reset data_out", data_out, '0);
    chk("reset valid", 64'(data_out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);

    // Ramp frame, accepted on the first edge after reset release.
    for (int n = 0; n < IW; n++)
      for (int f = 0; f < NF; f++)
        fr[(n*NF + f)*AB +: AB] = AB'(n*8 + f);
    rr = pool_ref(fr);
    chk("ref(0,0)", 64'(el(rr, 0, 0)), 64'd8);
    chk("ref(19,7)", 64'(el(rr, 19, 7)), 64'd319);
    rst_n = 1'b1;
    pulse(fr, t0);
    wait_valid("ramp latency", t0);
    chk("ramp out(0,0)", 64'(el(data_out, 0, 0)), 64'd8);
    chk("ramp out(19,7)", 64'(el(data_out, 19, 7)), 64'd319);
    chk("ramp out(5,3)", 64'(el(data_out, 5, 3)), 64'd91);

    // Unsigned compare and tie.
    fr = '0;
    fr[(0*NF)*AB +: AB] = 16'hFFFF;
    fr[(1*NF)*AB +: AB] = 16'h0001;
    pulse(fr, t0);
    wait_valid("unsigned latency", t0);
    chk("unsigned max", 64'(el(data_out, 0, 0)), 64'hFFFF);
    chk("tie zero", 64'(el(data_out, 1, 0)), 64'h0000);

    // Second strobe while busy is dropped.
    for (int i = 0; i < IN_BITS/32; i++) fa[i*32 +: 32] = $urandom;
    pulse(fa, t0);
    repeat (4) step();
    for (int i = 0; i < IN_BITS/32; i++) fr[i*32 +: 32] = $urandom;
    pulse(fr, t0);
    wait_valid("drop latency", t0 - 5);
    chk_frame("drop keeps frame 1", data_out, pool_ref(fa));
`ifdef MAXPOOL_DROP_CNT_EN
    chk("drop_count one", 64'(drop_count), 64'd1);
`endif
    repeat (30) step();

    // Reset mid-compute, then a clean frame.
    for (int i = 0; i < IN_BITS/32; i++) fr[i*32 +: 32] = $urandom;
    pulse(fr, t0);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    chk_frame("midreset data_out", data_out, '0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset valid", 64'(data_out_valid), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < IN_BITS/32; i++) fr[i*32 +: 32] = $urandom;
    pulse(fr, t0);
    wait_valid("post-reset latency", t0);
    chk_frame("post-reset frame", data_out, pool_ref(fr));

    // Random frames with random gaps (some dropped by design).
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < IN_BITS/32; i++) fr[i*32 +: 32] = $urandom;
      pulse(fr, t0);
      repeat ($urandom_range(0, 30)) step();
    end
    repeat (30) step();

    // Strobe held high long enough to saturate the drop counter.
    data_valid = 1'b1;
    for (int i = 0; i < 450; i++) begin
      for (int j = 0; j < IN_BITS/32; j++) data_in[j*32 +: 32] = $urandom;
      step();
    end
    data_valid = 1'b0;
    repeat (30) step();
`ifdef MAXPOOL_DROP_CNT_EN
    chk("drop_count saturated", 64'(drop_count), 64'd255);
`endif

    // Remainder position ignored: only positions 0..3 form windows.
    for (int n = 0; n < IW5; n++)
      for (int f = 0; f < NF5; f++)
        din5[(n*NF5 + f)*AB +: AB] = (n == 4) ? 16'h7FFF : 16'h0001;
    dv5 = 1'b1;
    step();
    dv5 = 1'b0;
    t0 = ecnt;
    begin
      int lat5;
      lat5 = -1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dov5) begin lat5 = ecnt - t0; break; end
      end
      #1;
      chk("remainder latency", 64'(lat5), 64'(OW5 + 1));
      chk("remainder out", 64'(dout5), 64'h0001_0001_0001_0001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
